// File: rtl/iterative_exec_unit_if.sv
// Request/writeback bundle between the register file read ports and the iterative execute unit.
// master: issues start/op/operands and observes status; slave: the execute unit.
interface iterative_exec_unit_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 2
);
  logic                  start;
  logic [2:0]            op;
  logic [WIDTH-1:0]      src1;
  logic [WIDTH-1:0]      src2;
  logic [REG_ADDR_W-1:0] dest;

  logic                  busy;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] write_register;
  logic [WIDTH-1:0]      write_data;
  logic                  zero;
  logic                  err;

  modport master (
    output start, op, src1, src2, dest,
    input  busy, write_enable, write_register, write_data, zero, err
  );

  modport slave (
    input  start, op, src1, src2, dest,
    output busy, write_enable, write_register, write_data, zero, err
  );
endinterface

// File: rtl/iterative_exec_unit.sv
// Execute stage: single-cycle ALU ops plus WIDTH-cycle shift-add MUL (and restoring DIV when EXEC_UNIT_DIV_EN).
// Write strobe 1 cycle after start (WIDTH+1 for MUL/DIV); start is dropped, not queued, while busy.
module iterative_exec_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 2
) (
  input logic                  clk,
  input logic                  reset,
  iterative_exec_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
`ifdef EXEC_UNIT_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b110;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]      cnt;
  // acc: product accumulator or partial remainder.
  // opa: multiplier (shifts right) or dividend/quotient (shifts left).
  // opb: multiplicand (shifts left) or divisor (static).
  logic [WIDTH-1:0]      acc;
  logic [WIDTH-1:0]      opa;
  logic [WIDTH-1:0]      opb;
  logic [REG_ADDR_W-1:0] dest_q;

  logic                  busy_q;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] wreg_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  zero_q;
  logic                  err_q;

  logic                  op_single;
  logic                  op_iter;
  logic [WIDTH-1:0]      single_res;
  logic [WIDTH-1:0]      step_acc;
  logic [WIDTH-1:0]      step_opa;
  logic [WIDTH-1:0]      step_opb;
  logic [WIDTH-1:0]      iter_res;

  logic                  accept_single;
  logic                  accept_iter;
  logic                  reject;
  logic                  last_iter;

`ifdef EXEC_UNIT_DIV_EN
  logic                  op_div;
  logic                  is_div;
  logic [WIDTH:0]        div_shift;
  logic                  div_ge;
  logic [WIDTH-1:0]      div_sub;
`endif

  // Opcode decode and single-cycle result from the live operands.
  always_comb begin
    op_single  = 1'b0;
    op_iter    = 1'b0;
    single_res = '0;
`ifdef EXEC_UNIT_DIV_EN
    op_div     = 1'b0;
`endif
    case (bus.op)
      OP_ADD: begin
        op_single  = 1'b1;
        single_res = bus.src1 + bus.src2;
      end
      OP_SUB: begin
        op_single  = 1'b1;
        single_res = bus.src1 - bus.src2;
      end
      OP_AND: begin
        op_single  = 1'b1;
        single_res = bus.src1 & bus.src2;
      end
      OP_OR: begin
        op_single  = 1'b1;
        single_res = bus.src1 | bus.src2;
      end
      OP_SLT: begin
        op_single  = 1'b1;
        single_res = {{(WIDTH-1){1'b0}}, (bus.src1 < bus.src2)};
      end
      OP_MUL: op_iter = 1'b1;
`ifdef EXEC_UNIT_DIV_EN
      OP_DIV: begin
        op_iter = 1'b1;
        op_div  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // One iteration step of the multi-cycle datapath.
  always_comb begin
    step_acc = acc + (opa[0] ? opb : '0);
    step_opa = opa >> 1;
    step_opb = opb << 1;
`ifdef EXEC_UNIT_DIV_EN
    div_shift = {acc, opa[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb});
    div_sub   = div_shift[WIDTH-1:0] - opb;
    // A zero divisor always "fits", which yields the all-ones quotient naturally.
    if (is_div) begin
      step_opb = opb;
      if (div_ge) begin
        step_acc = div_sub;
        step_opa = {opa[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = div_shift[WIDTH-1:0];
        step_opa = {opa[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

`ifdef EXEC_UNIT_DIV_EN
  assign iter_res = is_div ? step_opa : step_acc;
`else
  assign iter_res = step_acc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept_single = 1'b0;
    accept_iter   = 1'b0;
    reject        = 1'b0;
    last_iter     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (op_single) begin
            accept_single = 1'b1;
            state_nxt     = WB;
          end else if (op_iter) begin
            accept_iter = 1'b1;
            state_nxt   = ITER;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ITER: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_iter = 1'b1;
          state_nxt = WB;
        end
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
      dest_q  <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef EXEC_UNIT_DIV_EN
      is_div  <= 1'b0;
`endif
    end else begin
      busy_q <= (state_nxt != IDLE);
      we_q   <= accept_single | last_iter;
      err_q  <= reject;

      if (accept_single) begin
        wreg_q  <= bus.dest;
        wdata_q <= single_res;
        zero_q  <= (single_res == '0);
      end

      if (accept_iter) begin
        cnt    <= '0;
        acc    <= '0;
        dest_q <= bus.dest;
`ifdef EXEC_UNIT_DIV_EN
        is_div <= op_div;
        opa    <= op_div ? bus.src1 : bus.src2;
        opb    <= op_div ? bus.src2 : bus.src1;
`else
        opa    <= bus.src2;
        opb    <= bus.src1;
`endif
      end else if (state == ITER) begin
        cnt <= cnt + 1'b1;
        acc <= step_acc;
        opa <= step_opa;
        opb <= step_opb;
      end

      if (last_iter) begin
        wreg_q  <= dest_q;
        wdata_q <= iter_res;
        zero_q  <= (iter_res == '0);
      end
    end
  end

  assign bus.busy           = busy_q;
  assign bus.write_enable   = we_q;
  assign bus.write_register = wreg_q;
  assign bus.write_data     = wdata_q;
  assign bus.zero           = zero_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_iterative_exec_unit.sv
// Randomized and directed bench for iterative_exec_unit against an arithmetic reference model.
// Build with +define+EXEC_UNIT_DIV_EN to cover the divide option.
module tb_iterative_exec_unit;

  localparam int WIDTH = 32;
  localparam int RW    = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  iterative_exec_unit_if #(.WIDTH(WIDTH), .REG_ADDR_W(RW)) bus();

  iterative_exec_unit #(.WIDTH(WIDTH), .REG_ADDR_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] mdl_data = '0;
  logic [RW-1:0]    mdl_reg  = '0;
  logic             mdl_zero = 1'b0;

  function automatic void model(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic legal, output logic iter, output logic [WIDTH-1:0] r);
    logic [2*WIDTH-1:0] p;
    legal = 1'b1;
    iter  = 1'b0;
    r     = '0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin
        iter = 1'b1;
        p    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        r    = p[WIDTH-1:0];
      end
      3'd5: r = (a < b) ? WIDTH'(1) : '0;
      3'd6: begin
`ifdef EXEC_UNIT_DIV_EN
        iter = 1'b1;
        r    = (b == '0) ? '1 : a / b;
`else
        legal = 1'b0;
`endif
      end
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return WIDTH'($urandom_range(0, 15));
      1:       return '1;
      2:       return '0;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Issue one op; inject_at >= 0 raises an extra ADD start at that cycle offset, which must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [RW-1:0] d, input int inject_at, input string name);
    logic             legal, iter;
    logic [WIDTH-1:0] r;
    int               lat, seen;
    logic             flags_ok;
    model(op, a, b, legal, iter, r);
    lat = iter ? WIDTH : 0;

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src1  = a;
    bus.src2  = b;
    bus.dest  = d;

    if (legal) begin
      seen     = -1;
      flags_ok = 1'b1;
      for (int k = 0; k <= WIDTH + 4; k++) begin
        @(negedge clk);
        bus.start = (k == inject_at);
        bus.op    = 3'b000;
        bus.src1  = WIDTH'(1);
        bus.src2  = WIDTH'(1);
        bus.dest  = ~d;
        if (bus.err !== 1'b0) flags_ok = 1'b0;
        if (bus.write_enable === 1'b1) begin
          seen = k;
          break;
        end
        if (bus.busy !== 1'b1) flags_ok = 1'b0;
      end
      vectors++;
      if (seen != lat) begin
        miscompares++;
        $display("FAIL %s latency: got %0d cycles expected %0d", name, seen + 1, lat + 1);
      end
      if (seen >= 0) begin
        vectors++;
        if (bus.write_data !== r || bus.write_register !== d || bus.zero !== (r == '0) ||
            bus.busy !== 1'b1 || !flags_ok) begin
          miscompares++;
          $display("FAIL %s writeback: got data=%0h reg=%0d zero=%0b busy=%0b flags_ok=%0b expected data=%0h reg=%0d zero=%0b busy=1 flags_ok=1",
                   name, bus.write_data, bus.write_register, bus.zero, bus.busy, flags_ok, r, d, (r == '0));
        end
      end
      mdl_data = r;
      mdl_reg  = d;
      mdl_zero = (r == '0);
      @(negedge clk);
      bus.start = 1'b0;
      vectors++;
      if (bus.write_enable !== 1'b0 || bus.busy !== 1'b0 || bus.write_data !== mdl_data ||
          bus.write_register !== mdl_reg || bus.zero !== mdl_zero) begin
        miscompares++;
        $display("FAIL %s after_wb: got we=%0b busy=%0b data=%0h reg=%0d zero=%0b expected we=0 busy=0 data=%0h reg=%0d zero=%0b",
                 name, bus.write_enable, bus.busy, bus.write_data, bus.write_register, bus.zero,
                 mdl_data, mdl_reg, mdl_zero);
      end
    end else begin
      @(negedge clk);
      bus.start = 1'b0;
      vectors++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.write_enable !== 1'b0) begin
        miscompares++;
        $display("FAIL %s illegal_pulse: got err=%0b busy=%0b we=%0b expected err=1 busy=0 we=0",
                 name, bus.err, bus.busy, bus.write_enable);
      end
      @(negedge clk);
      vectors++;
      if (bus.err !== 1'b0 || bus.write_enable !== 1'b0 || bus.busy !== 1'b0 ||
          bus.write_data !== mdl_data || bus.zero !== mdl_zero) begin
        miscompares++;
        $display("FAIL %s illegal_after: got err=%0b we=%0b busy=%0b data=%0h zero=%0b expected err=0 we=0 busy=0 data=%0h zero=%0b",
                 name, bus.err, bus.write_enable, bus.busy, bus.write_data, bus.zero, mdl_data, mdl_zero);
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.src1  = '0;
    bus.src2  = '0;
    bus.dest  = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.write_enable !== 1'b0 || bus.write_register !== '0 ||
        bus.write_data !== '0 || bus.zero !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%0b we=%0b reg=%0d data=%0h zero=%0b err=%0b expected all 0",
               bus.busy, bus.write_enable, bus.write_register, bus.write_data, bus.zero, bus.err);
    end
    reset = 1'b0;
    mdl_data = '0;
    mdl_reg  = '0;
    mdl_zero = 1'b0;
  endtask

  task automatic test_add();
    run_op(3'b000, 32'd5, 32'd7, 2'd2, -1, "add_5_7");
  endtask

  task automatic test_wrap_zero();
    run_op(3'b001, 32'd3, 32'd3, 2'd1, -1, "sub_zero");
    run_op(3'b011, 32'h0000_00F0, 32'h0F00_0000, 2'd3, -1, "or_nonzero");
    run_op(3'b000, 32'hFFFF_FFFF, 32'd1, 2'd0, -1, "add_wrap");
    run_op(3'b101, 32'd4, 32'hFFFF_FFFF, 2'd2, -1, "slt_unsigned");
    run_op(3'b101, 32'hFFFF_FFFF, 32'd4, 2'd2, -1, "slt_false");
  endtask

  task automatic test_mul();
    run_op(3'b100, 32'h0001_0000, 32'h0003_0003, 2'd1, 9, "mul_directed");
    run_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, -1, "mul_max");
  endtask

  task automatic test_illegal();
    run_op(3'b010, 32'hDEAD_BEEF, 32'hFFFF_0000, 2'd1, -1, "and_setup");
    run_op(3'b111, 32'd1, 32'd2, 2'd3, -1, "illegal_111");
    run_op(3'b110, 32'd50, 32'd5, 2'd2, -1, "op_110");
  endtask

  // Start held through WB must be ignored there and accepted in the first IDLE cycle.
  task automatic test_back_to_back();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.src1  = 32'd100;
    bus.src2  = 32'd23;
    bus.dest  = 2'd1;
    @(negedge clk);
    bus.op    = 3'b011;
    bus.src1  = 32'h0000_0A00;
    bus.src2  = 32'h0000_000B;
    bus.dest  = 2'd2;
    vectors++;
    if (bus.write_enable !== 1'b1 || bus.write_data !== 32'd123 || bus.write_register !== 2'd1) begin
      miscompares++;
      $display("FAIL b2b_first: got we=%0b data=%0h reg=%0d expected we=1 data=7b reg=1",
               bus.write_enable, bus.write_data, bus.write_register);
    end
    @(negedge clk);
    vectors++;
    if (bus.write_enable !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_wb_ignore: got we=%0b busy=%0b expected we=0 busy=0", bus.write_enable, bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    vectors++;
    if (bus.write_enable !== 1'b1 || bus.write_data !== 32'h0000_0A0B || bus.write_register !== 2'd2) begin
      miscompares++;
      $display("FAIL b2b_second: got we=%0b data=%0h reg=%0d expected we=1 data=a0b reg=2",
               bus.write_enable, bus.write_data, bus.write_register);
    end
    mdl_data = 32'h0000_0A0B;
    mdl_reg  = 2'd2;
    mdl_zero = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int stray;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.src1  = 32'h0001_0000;
    bus.src2  = 32'h0003_0003;
    bus.dest  = 2'd1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.write_enable !== 1'b0 || bus.write_data !== '0 ||
        bus.write_register !== '0 || bus.zero !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_mul: got busy=%0b we=%0b data=%0h reg=%0d zero=%0b err=%0b expected all 0",
               bus.busy, bus.write_enable, bus.write_data, bus.write_register, bus.zero, bus.err);
    end
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    mdl_data = '0;
    mdl_reg  = '0;
    mdl_zero = 1'b0;
    stray    = 0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(negedge clk);
      if (bus.write_enable !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL reset_no_write: got %0d active cycles expected 0", stray);
    end
    run_op(3'b000, 32'd1, 32'd1, 2'd0, -1, "add_after_reset");
  endtask

  task automatic test_div();
    run_op(3'b110, 32'd100, 32'd7, 2'd3, -1, "div_100_7");
    run_op(3'b110, 32'd9, 32'd0, 2'd0, -1, "div_by_zero");
    run_op(3'b110, 32'hFFFF_FFFF, 32'd1, 2'd1, -1, "div_by_one");
    run_op(3'b110, 32'd3, 32'd10, 2'd2, -1, "div_small");
  endtask

  task automatic test_random();
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    int               inj;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_op(op, a, b, RW'($urandom_range(0, 3)), inj, "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap_zero();
    test_mul();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mul();
    test_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
